// File: rtl/k2red_ln_shift_mul_src.sv
// Radix-2^RADIX_LOG shift-add multiplier feeding the k2red_ln_shift reducer.
// Latency N=LOG_Q/RADIX_LOG cycles from accept to a one-cycle valid_out; ready_out only in IDLE.
module k2red_ln_shift_mul_src #(
  parameter int LOG_Q     = 32,
  parameter int LOG_L     = 4,
  parameter int RADIX_LOG = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LOG_Q-1:0]     X,
  input  logic [LOG_Q-1:0]     Y,
  input  logic [LOG_Q-1:0]     Q_in,
  input  logic [LOG_L-1:0]     l1_in,
  input  logic [LOG_L-1:0]     l2_in,
  input  logic [LOG_L-1:0]     l3_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic [2*LOG_Q-1:0]   A,
  output logic [LOG_Q-1:0]     Q,
  output logic [LOG_L-1:0]     l1,
  output logic [LOG_L-1:0]     l2,
  output logic [LOG_L-1:0]     l3,
  output logic                 valid_out
);

  localparam int N  = LOG_Q / RADIX_LOG;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(2 * LOG_Q);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t               state_q;
  logic [LOG_Q-1:0]     mcand_q;
  logic [LOG_Q-1:0]     mplier_q;
  logic [2*LOG_Q-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;
  logic [LOG_Q-1:0]     q_sh_q;
  logic [LOG_L-1:0]     l1_sh_q, l2_sh_q, l3_sh_q;
  logic [2*LOG_Q-1:0]   a_q;
  logic [LOG_Q-1:0]     q_q;
  logic [LOG_L-1:0]     l1_q, l2_q, l3_q;
  logic                 valid_out_q;

  logic [2*LOG_Q-1:0]   mcand_ext;
  logic [2*LOG_Q-1:0]   digit_ext;
  logic [SW-1:0]        shamt;
  logic [2*LOG_Q-1:0]   acc_d;
  logic                 last_step;

  // Partial product is at most LOG_Q+RADIX_LOG bits, shifted by at most LOG_Q-RADIX_LOG: never overflows.
  always_comb begin
    mcand_ext = '0;
    digit_ext = '0;
    mcand_ext[LOG_Q-1:0]     = mcand_q;
    digit_ext[RADIX_LOG-1:0] = mplier_q[RADIX_LOG-1:0];
    shamt     = SW'(cnt_q) * SW'(RADIX_LOG);
    acc_d     = acc_q + ((mcand_ext * digit_ext) << shamt);
    last_step = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      q_sh_q      <= '0;
      l1_sh_q     <= '0;
      l2_sh_q     <= '0;
      l3_sh_q     <= '0;
      a_q         <= '0;
      q_q         <= '0;
      l1_q        <= '0;
      l2_q        <= '0;
      l3_q        <= '0;
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            mcand_q  <= X;
            mplier_q <= Y;
            acc_q    <= '0;
            q_sh_q   <= Q_in;
            l1_sh_q  <= l1_in;
            l2_sh_q  <= l2_in;
            l3_sh_q  <= l3_in;
            cnt_q    <= '0;
            state_q  <= MUL;
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> RADIX_LOG;
          cnt_q    <= cnt_q + CW'(1);
          if (last_step) begin
            a_q         <= acc_d;
            q_q         <= q_sh_q;
            l1_q        <= l1_sh_q;
            l2_q        <= l2_sh_q;
            l3_q        <= l3_sh_q;
            valid_out_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_out = (state_q == IDLE) && !rst;
  assign A         = a_q;
  assign Q         = q_q;
  assign l1        = l1_q;
  assign l2        = l2_q;
  assign l3        = l3_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_k2red_ln_shift_mul_src.sv
// Directed + randomized bench for k2red_ln_shift_mul_src against a plain X*Y product model.
module tb_k2red_ln_shift_mul_src;
  localparam int LOG_Q = 32;
  localparam int LOG_L = 4;
  localparam int RL    = 2;
  localparam int N     = LOG_Q / RL;

  logic               clk = 1'b0;
  logic               rst;
  logic [LOG_Q-1:0]   X, Y, Q_in;
  logic [LOG_L-1:0]   l1_in, l2_in, l3_in;
  logic               valid_in;
  logic               ready_out;
  logic [2*LOG_Q-1:0] A;
  logic [LOG_Q-1:0]   Q;
  logic [LOG_L-1:0]   l1, l2, l3;
  logic               valid_out;

  int tests = 0;
  int fails = 0;

  // Model: visible outputs held since last completion, and the result owed by the operation in flight.
  logic [63:0]      exp_a, pend_a;
  logic [LOG_Q-1:0] exp_q, pend_q;
  logic [LOG_L-1:0] exp_l1, exp_l2, exp_l3, pend_l1, pend_l2, pend_l3;

  k2red_ln_shift_mul_src #(.LOG_Q(LOG_Q), .LOG_L(LOG_L), .RADIX_LOG(RL)) dut (
    .clk(clk), .rst(rst), .X(X), .Y(Y), .Q_in(Q_in),
    .l1_in(l1_in), .l2_in(l2_in), .l3_in(l3_in), .valid_in(valid_in),
    .ready_out(ready_out), .A(A), .Q(Q), .l1(l1), .l2(l2), .l3(l3),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_pend(input logic [31:0] x, input logic [31:0] y, input logic [31:0] q,
                          input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    pend_a  = {32'd0, x} * {32'd0, y};
    pend_q  = q;
    pend_l1 = a;
    pend_l2 = b;
    pend_l3 = c;
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_vld"}, {63'd0, valid_out}, 64'd0);
    check({tag, "_A"}, A, exp_a);
    check({tag, "_Q"}, {32'd0, Q}, {32'd0, exp_q});
    check({tag, "_l"}, {52'd0, l1, l2, l3}, {52'd0, exp_l1, exp_l2, exp_l3});
  endtask

  task automatic mul_cycle(input string tag);
    check({tag, "_busy_rdy"}, {63'd0, ready_out}, 64'd0);
    check_hold({tag, "_busy"});
  endtask

  task automatic finish_cycle(input string tag);
    check({tag, "_done_vld"}, {63'd0, valid_out}, 64'd1);
    check({tag, "_done_rdy"}, {63'd0, ready_out}, 64'd1);
    check({tag, "_done_A"}, A, pend_a);
    check({tag, "_done_Q"}, {32'd0, Q}, {32'd0, pend_q});
    check({tag, "_done_l"}, {52'd0, l1, l2, l3}, {52'd0, pend_l1, pend_l2, pend_l3});
    exp_a = pend_a; exp_q = pend_q;
    exp_l1 = pend_l1; exp_l2 = pend_l2; exp_l3 = pend_l3;
  endtask

  task automatic start(input logic [31:0] x, input logic [31:0] y, input logic [31:0] q,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    int n;
    X = x; Y = y; Q_in = q; l1_in = a; l2_in = b; l3_in = c;
    valid_in = 1'b1;
    n = 0;
    while (ready_out !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("accept_ready", {63'd0, ready_out}, 64'd1);
    set_pend(x, y, q, a, b, c);
    step();
    valid_in = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] q, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] c);
    start(x, y, q, a, b, c);
    for (int k = 1; k < N; k++) begin
      step();
      mul_cycle(tag);
    end
    step();
    finish_cycle(tag);
    step();
    check({tag, "_pulse_once"}, {63'd0, valid_out}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0;
    X = '0; Y = '0; Q_in = '0; l1_in = '0; l2_in = '0; l3_in = '0;
    exp_a = '0; exp_q = '0; exp_l1 = '0; exp_l2 = '0; exp_l3 = '0;
    pend_a = '0; pend_q = '0; pend_l1 = '0; pend_l2 = '0; pend_l3 = '0;

    // Reset then idle
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_rdy", {63'd0, ready_out}, 64'd0);
      check_hold("rst");
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      check("idle_rdy", {63'd0, ready_out}, 64'd1);
      check_hold("idle");
    end

    // Nominal product and width boundaries
    run("nominal", 32'd123456789, 32'd1000, 32'd2148794369, 4'd2, 4'd1, 4'd3);
    run("maxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 4'd15, 4'd15);
    check("maxmax_const", exp_a, 64'd18446744065119617025);
    run("zero", 32'd0, 32'hFFFF_FFFF, 32'd97, 4'd0, 4'd5, 4'd9);

    // Busy rejection, then a request held into the completion cycle
    start(32'd3, 32'd5, 32'd2148794369, 4'd2, 4'd1, 4'd3);
    for (int k = 1; k < N; k++) begin
      step();
      mul_cycle("busy");
      if (k == 4) begin X = 32'd7; Y = 32'd7; valid_in = 1'b1; end
      if (k == 5) valid_in = 1'b0;
      if (k == 10) begin X = 32'd65536; Y = 32'd65536; valid_in = 1'b1; end
    end
    step();
    finish_cycle("busy");
    check("busy_A15", A, 64'd15);
    set_pend(32'd65536, 32'd65536, 32'd2148794369, 4'd2, 4'd1, 4'd3);
    step();
    valid_in = 1'b0;
    check("b2b_pulse_once", {63'd0, valid_out}, 64'd0);
    check("b2b_accepted_rdy", {63'd0, ready_out}, 64'd0);
    for (int k = 1; k < N; k++) begin
      step();
      mul_cycle("b2b");
    end
    step();
    finish_cycle("b2b");
    check("b2b_const", A, 64'd4294967296);
    step();

    // Reset mid-operation discards the partial product
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2148794369, 4'd2, 4'd1, 4'd3);
    for (int k = 1; k < 8; k++) begin
      step();
      mul_cycle("midrst");
    end
    rst = 1'b1;
    step();
    exp_a = '0; exp_q = '0; exp_l1 = '0; exp_l2 = '0; exp_l3 = '0;
    check("midrst_rdy", {63'd0, ready_out}, 64'd0);
    check_hold("midrst_in");
    rst = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      step();
      check("midrst_rdy_after", {63'd0, ready_out}, 64'd1);
      check_hold("midrst_after");
    end
    run("postrst", 32'd123456789, 32'd1000, 32'd2148794369, 4'd2, 4'd1, 4'd3);

    // Randomized operations with random idle gaps
    for (int r = 0; r < 24; r++) begin
      logic [31:0] rx, ry;
      int gap;
      rx = $urandom;
      ry = $urandom;
      if (r % 8 == 3) rx = 32'hFFFF_FFFF;
      if (r % 8 == 5) ry = 32'd1;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        check("gap_rdy", {63'd0, ready_out}, 64'd1);
        check_hold("gap");
        step();
      end
      run("rand", rx, ry, $urandom, 4'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
